// File: rtl/dram_pkg.sv
// dram_pkg: shared load/store codes and WB state encoding for the data SRAM port.
package dram_pkg;
  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LBU  = 3'b010;
  localparam logic [2:0] LD_LH   = 3'b011;
  localparam logic [2:0] LD_LHU  = 3'b100;
  localparam logic [2:0] LD_LW   = 3'b111;
  localparam logic [2:0] ST_SB   = 3'b101;
  localparam logic [2:0] ST_SH   = 3'b110;
  localparam logic [2:0] ST_SW   = 3'b111;
  typedef enum logic [1:0] {IDLE, FRESH, HELD} wb_state_e;
  function automatic logic is_load(input logic [2:0] t);
    return t inside {LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW};
  endfunction
endpackage

// File: rtl/dram_load_ext.sv
// dram_load_ext: extract and sign/zero-extend a byte, halfword or word from an SRAM word.
module dram_load_ext
  import dram_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  addr_byte,
  input  logic [31:0] word,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{addr_byte, 3'b000} +: 8];
    h = addr_byte[1] ? word[31:16] : word[15:0];
    result = load_type == LD_LB  ? {{24{b[7]}}, b} :
             load_type == LD_LBU ? {24'b0, b} :
             load_type == LD_LH  ? {{16{h[15]}}, h} :
             load_type == LD_LHU ? {16'b0, h} :
             load_type == LD_LW  ? word : '0;
  end
endmodule

// File: rtl/dram_load_align.sv
// dram_load_align: MEM-stage load decode/SRAM read enable and WB-stage data capture, hold and alignment.
module dram_load_align
  import dram_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid_mem,
  input  logic [2:0]        load_type_mem,
  input  logic [1:0]        data_sram_addr_byte_mem,
  input  logic              flush,
  input  logic              stall_wb,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic              load_req_mem,
  output logic              adel_mem,
  output logic              load_valid_wb,
  output logic [DATA_W-1:0] load_data_wb
);
  wb_state_e         state_q, state_d;
  logic [2:0]        type_q, type_d;
  logic [1:0]        byte_q, byte_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] src_word, ext_word;
  always_comb begin
    adel_mem = valid_mem & (((load_type_mem == LD_LH || load_type_mem == LD_LHU) & data_sram_addr_byte_mem[0]) |
                            ((load_type_mem == LD_LW) & |data_sram_addr_byte_mem));
    load_req_mem = valid_mem & is_load(load_type_mem) & ~adel_mem & ~flush;
    state_d = state_q;
    type_d  = type_q;
    byte_d  = byte_q;
    hold_d  = hold_q;
    if (flush) begin
      state_d = IDLE;
      type_d  = LD_NONE;
      byte_d  = '0;
    end else if (!stall_wb) begin
      state_d = load_req_mem ? FRESH : IDLE;
      type_d  = load_req_mem ? load_type_mem : LD_NONE;
      byte_d  = load_req_mem ? data_sram_addr_byte_mem : '0;
    end else if (state_q == FRESH) begin
      // SRAM data lasts one cycle, so a stalled fresh result must be captured now
      state_d = HELD;
      hold_d  = data_sram_rdata;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      type_q  <= LD_NONE;
      byte_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      byte_q  <= byte_d;
      hold_q  <= hold_d;
    end
  end
  assign src_word = state_q == HELD ? hold_q : data_sram_rdata;
  dram_load_ext u_ext (
    .load_type (type_q),
    .addr_byte (byte_q),
    .word      (src_word),
    .result    (ext_word)
  );
  assign load_valid_wb = state_q != IDLE;
  assign load_data_wb  = state_q == IDLE ? '0 : ext_word;
endmodule

// File: tb/tb_dram_load_align.sv
// tb_dram_load_align: randomized and directed checks against a behavioural load-alignment model.
module tb_dram_load_align;
  logic        clk = 0;
  logic        resetn, valid_mem, flush, stall_wb;
  logic [2:0]  load_type_mem;
  logic [1:0]  data_sram_addr_byte_mem;
  logic [31:0] data_sram_rdata;
  logic        load_req_mem, adel_mem, load_valid_wb;
  logic [31:0] load_data_wb;
  int checks = 0, errors = 0;
  bit          m_valid, m_fresh;
  logic [2:0]  m_type;
  logic [1:0]  m_byte;
  logic [31:0] m_hold;

  dram_load_align #(.DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .valid_mem(valid_mem), .load_type_mem(load_type_mem),
    .data_sram_addr_byte_mem(data_sram_addr_byte_mem), .flush(flush), .stall_wb(stall_wb),
    .data_sram_rdata(data_sram_rdata), .load_req_mem(load_req_mem), .adel_mem(adel_mem),
    .load_valid_wb(load_valid_wb), .load_data_wb(load_data_wb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int access_size(input logic [2:0] t);
    case (t)
      3'd1, 3'd2: return 1;
      3'd3, 3'd4: return 2;
      3'd7:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_ext(input logic [2:0] t, input logic [1:0] b, input logic [31:0] w);
    longint v;
    case (t)
      3'd1, 3'd2: begin
        v = (w >> (8 * int'(b))) & 32'hFF;
        if (t == 3'd1 && v >= 128) v -= 256;
      end
      3'd3, 3'd4: begin
        v = (w >> (16 * (int'(b) / 2))) & 32'hFFFF;
        if (t == 3'd3 && v >= 32768) v -= 65536;
      end
      3'd7: v = w;
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  task automatic cyc(input bit rn, input bit v, input logic [2:0] t, input logic [1:0] a,
                     input bit f, input bit s, input logic [31:0] rd,
                     input logic [31:0] kexp = '0, input bit kon = 0);
    bit eadel, ereq;
    int sz;
    resetn = rn; valid_mem = v; load_type_mem = t; data_sram_addr_byte_mem = a;
    flush = f; stall_wb = s; data_sram_rdata = rd;
    #1;
    sz = access_size(t);
    eadel = v && sz != 0 && (int'(a) % sz) != 0;
    ereq  = v && sz != 0 && !eadel && !f;
    check("adel", {31'b0, adel_mem}, {31'b0, eadel});
    check("req", {31'b0, load_req_mem}, {31'b0, ereq});
    check("valid", {31'b0, load_valid_wb}, {31'b0, m_valid});
    check("data", load_data_wb, m_valid ? ref_ext(m_type, m_byte, m_fresh ? rd : m_hold) : 32'h0);
    if (kon) check("directed", load_data_wb, kexp);
    @(posedge clk);
    if (!rn) begin
      m_valid = 0; m_fresh = 0; m_hold = 0; m_type = 0; m_byte = 0;
    end else if (f) begin
      m_valid = 0;
    end else if (!s) begin
      m_valid = ereq; m_fresh = 1; m_type = t; m_byte = a;
    end else if (m_valid && m_fresh) begin
      m_fresh = 0; m_hold = rd;
    end
    @(negedge clk);
  endtask

  initial begin
    resetn = 0; valid_mem = 0; load_type_mem = 0; data_sram_addr_byte_mem = 0;
    flush = 0; stall_wb = 0; data_sram_rdata = 0;
    m_valid = 0; m_fresh = 0; m_hold = 0; m_type = 0; m_byte = 0;
    @(posedge clk);
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 32'h1234_5678);
    cyc(1, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'h0, 1);
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    cyc(1, 1, 3'd1, 2'd3, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 32'h80FF_1234, 32'hFFFF_FF80, 1);
    cyc(1, 1, 3'd2, 2'd3, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 32'h80FF_1234, 32'h0000_0080, 1);
    cyc(1, 1, 3'd3, 2'd2, 0, 0, 32'h0);
    cyc(1, 1, 3'd4, 2'd0, 0, 0, 32'h8001_7FFF, 32'hFFFF_8001, 1);
    cyc(1, 1, 3'd7, 2'd0, 0, 0, 32'h8001_7FFF, 32'h0000_7FFF, 1);
    cyc(1, 0, 0, 0, 0, 0, 32'h8001_7FFF, 32'h8001_7FFF, 1);
    cyc(1, 1, 3'd3, 2'd1, 0, 0, 32'h0);
    cyc(1, 1, 3'd7, 2'd2, 0, 0, 32'h0, 32'h0, 1);
    cyc(1, 0, 0, 0, 0, 0, 32'h5555_5555, 32'h0, 1);
    cyc(1, 1, 3'd5, 2'd0, 0, 0, 32'h0);
    cyc(1, 1, 3'd6, 2'd0, 0, 0, 32'h0, 32'h0, 1);
    cyc(1, 1, 3'd7, 2'd0, 0, 0, 32'h0, 32'h0, 1);
    cyc(1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
    cyc(1, 0, 0, 0, 0, 1, 32'h0, 32'hDEAD_BEEF, 1);
    cyc(1, 0, 0, 0, 0, 1, 32'h0, 32'hDEAD_BEEF, 1);
    cyc(1, 0, 0, 0, 0, 0, 32'h0, 32'hDEAD_BEEF, 1);
    cyc(1, 1, 3'd7, 2'd0, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
    cyc(1, 0, 0, 0, 1, 1, 32'h0, 32'hCAFE_F00D, 1);
    cyc(1, 0, 0, 0, 0, 0, 32'h1111_1111, 32'h0, 1);
    cyc(1, 1, 3'd7, 2'd0, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 1, 32'h0BAD_CAFE);
    cyc(0, 0, 0, 0, 0, 1, 32'h0, 32'h0BAD_CAFE, 1);
    cyc(1, 0, 0, 0, 0, 0, 32'h2222_2222, 32'h0, 1);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(63) != 0, $urandom_range(3) != 0, 3'($urandom_range(7)), 2'($urandom_range(3)),
          $urandom_range(15) == 0, $urandom_range(3) == 0, $urandom);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
